// File: rtl/riscV_unrn_pkg.sv
// riscV_unrn_pkg: shared CSR addresses, bit positions and FSM states for the trap controller
package riscV_unrn_pkg;
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;
    localparam logic [11:0] CSR_MIP     = 12'h344;
    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MIX_MTI      = 7;
    typedef enum logic {IDLE, REDIRECT} trap_state_t;
endpackage

// File: rtl/trap_csr_file.sv
// trap_csr_file: trap CSR storage, write masks and read mux (vectored mtvec mode under TRAP_VECTORED_EN)
module trap_csr_file
    import riscV_unrn_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0004
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        mtip,
    input  logic        trap,
    input  logic        mret,
    input  logic [31:0] epc,
    input  logic [31:0] cause,
    input  logic [31:0] info,
    output logic        mie_en,
    output logic        mtie_en,
    output logic [31:0] mtvec,
    output logic [31:0] mepc
);
    logic        st_mie, st_mpie, mtie;
    logic [31:0] mcause, mtval;
    logic [31:0] mstatus_rd, mie_rd, mip_rd, mtvec_wr;

`ifdef TRAP_VECTORED_EN
    assign mtvec_wr = {wdata[31:2], 1'b0, wdata[1:0] == 2'b01};
`else
    assign mtvec_wr = wdata & ~32'h3;
`endif

    assign mie_en  = st_mie;
    assign mtie_en = mtie;

    // Commit updates own mstatus/mepc/mcause/mtval; software writes fill in otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_mie  <= 1'b0;
            st_mpie <= 1'b0;
            mtie    <= 1'b0;
`ifdef TRAP_VECTORED_EN
            mtvec   <= MTVEC_RESET;
`else
            mtvec   <= MTVEC_RESET & ~32'h3;
`endif
            mepc    <= '0;
            mcause  <= '0;
            mtval   <= '0;
        end else begin
            if (trap) begin
                st_mpie <= st_mie;
                st_mie  <= 1'b0;
                mepc    <= epc & ~32'h3;
                mcause  <= cause;
                mtval   <= info;
            end else if (mret) begin
                st_mie  <= st_mpie;
                st_mpie <= 1'b1;
            end else if (we) begin
                if (addr == CSR_MSTATUS) begin
                    st_mie  <= wdata[MSTATUS_MIE];
                    st_mpie <= wdata[MSTATUS_MPIE];
                end
                if (addr == CSR_MEPC)   mepc   <= wdata & ~32'h3;
                if (addr == CSR_MCAUSE) mcause <= wdata;
                if (addr == CSR_MTVAL)  mtval  <= wdata;
            end
            if (we && addr == CSR_MIE)   mtie  <= wdata[MIX_MTI];
            if (we && addr == CSR_MTVEC) mtvec <= mtvec_wr;
        end
    end

    // Read mux; unmapped addresses return zero
    always_comb begin
        mstatus_rd = '0;
        mstatus_rd[MSTATUS_MIE]  = st_mie;
        mstatus_rd[MSTATUS_MPIE] = st_mpie;
        mie_rd = '0;
        mie_rd[MIX_MTI] = mtie;
        mip_rd = '0;
        mip_rd[MIX_MTI] = mtip;
        rdata = '0;
        case (addr)
            CSR_MSTATUS: rdata = mstatus_rd;
            CSR_MIE:     rdata = mie_rd;
            CSR_MTVEC:   rdata = mtvec;
            CSR_MEPC:    rdata = mepc;
            CSR_MCAUSE:  rdata = mcause;
            CSR_MTVAL:   rdata = mtval;
            CSR_MIP:     rdata = mip_rd;
            default:     rdata = '0;
        endcase
    end
endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: M-mode trap/mret sequencing with registered fetch redirect (vectored interrupts under TRAP_VECTORED_EN)
module trap_ctrl
    import riscV_unrn_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0004
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        excPresent_i,
    input  logic [31:0] excCause_i,
    input  logic [31:0] trapInfo_i,
    input  logic [31:0] pc_i,
    input  logic        mret_i,
    input  logic        mtip_i,
    input  logic [11:0] csrAddr_i,
    input  logic        csrWe_i,
    input  logic [31:0] csrWdata_i,
    output logic [31:0] csrRdata_o,
    input  logic        fetchReady_i,
    output logic        redirect_o,
    output logic [31:0] redirectPc_o,
    output logic        stall_o,
    output logic        trapTaken_o
);
    trap_state_t state, state_next;
    logic        trap_take, mret_take, mie_en, mtie_en;
    logic [31:0] mtvec, mepc, base, vec;

    trap_csr_file #(.MTVEC_RESET(MTVEC_RESET)) u_csr (
        .clk(clk_i), .rst(rst_i), .addr(csrAddr_i), .we(csrWe_i), .wdata(csrWdata_i),
        .rdata(csrRdata_o), .mtip(mtip_i), .trap(trap_take), .mret(mret_take),
        .epc(pc_i), .cause(excCause_i), .info(trapInfo_i),
        .mie_en(mie_en), .mtie_en(mtie_en), .mtvec(mtvec), .mepc(mepc)
    );

    assign base = mtvec & ~32'h3;
`ifdef TRAP_VECTORED_EN
    assign vec = (mtvec[0] && excCause_i[31]) ? base + {excCause_i[29:0], 2'b00} : base;
`else
    assign vec = base;
`endif

    // Trap beats mret; requests are only looked at in IDLE
    always_comb begin
        trap_take  = state == IDLE && excPresent_i && (!excCause_i[31] || (mie_en && mtie_en));
        mret_take  = state == IDLE && mret_i && !trap_take;
        stall_o    = state == REDIRECT || trap_take || mret_take;
        state_next = (trap_take || mret_take) ? REDIRECT :
                     (state == REDIRECT && fetchReady_i) ? IDLE : state;
    end

    // State and registered redirect, held until fetch accepts it
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            redirect_o   <= 1'b0;
            redirectPc_o <= '0;
            trapTaken_o  <= 1'b0;
        end else begin
            state       <= state_next;
            trapTaken_o <= trap_take;
            if (trap_take || mret_take) begin
                redirect_o   <= 1'b1;
                redirectPc_o <= trap_take ? vec : mepc;
            end else if (state == REDIRECT && fetchReady_i) begin
                redirect_o   <= 1'b0;
            end
        end
    end
endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Machine-mode trap controller directly downstream of the exception detector. Consumes the detector's present/cause/info triple plus `mret`, and owns the trap CSRs `mstatus`, `mie`, `mtvec`, `mepc`, `mcause`, `mtval` and `mip`. On a trap or return it stalls the pipeline and drives a registered PC redirect to fetch. Fetch acknowledges the redirect with a handshake.

## Interface
- `MTVEC_RESET`, 32'h0000_0004, reset value of `mtvec`.
- `clk_i` in 1: clock.
- `rst_i` in 1: asynchronous reset, active-high.
- `excPresent_i` in 1: exception/interrupt request from the detector.
- `excCause_i` in 32: cause code; bit 31 set means interrupt.
- `trapInfo_i` in 32: value for `mtval`.
- `pc_i` in 32: PC of the instruction in the detect stage.
- `mret_i` in 1: an `mret` is in the detect stage.
- `mtip_i` in 1: timer pending level, reflected in `mip.MTIP` (bit 7).
- `csrAddr_i` in 12: CSR address.
- `csrWe_i` in 1: CSR write enable.
- `csrWdata_i` in 32: CSR write data.
- `csrRdata_o` out 32: combinational read data; unmapped addresses read 0.
- `fetchReady_i` in 1: fetch accepts the redirect.
- `redirect_o` out 1: redirect valid; registered.
- `redirectPc_o` out 32: redirect target; registered.
- `stall_o` out 1: freeze the upstream stages.
- `trapTaken_o` out 1: single-cycle pulse when a trap is committed.

## Operation
- **FSM states:** `IDLE`, `REDIRECT`.
- **IDLE, trap is taken when** `excPresent_i` is high and one of the following holds:
  - `excCause_i[31]` is 0 (synchronous exception), or
  - `excCause_i[31]` is 1 and both `mstatus.MIE` (bit 3) and `mie.MTIE` (bit 7) are 1.
- **IDLE, an interrupt request with either enable clear** is ignored. The FSM stays in `IDLE`.
- **Trap commit, at the clock edge:**
  - `mepc` <= {`pc_i[31:2]`, 2'b00}.
  - `mcause` <= `excCause_i`.
  - `mtval` <= `trapInfo_i`.
  - `mstatus.MPIE` <= `MIE`; `mstatus.MIE` <= 0.
  - Target <= trap vector (see Configuration).
  - FSM -> `REDIRECT`.
- **IDLE, `mret_i` with no trap taken:**
  - `mstatus.MIE` <= `MPIE`; `MPIE` <= 1.
  - Target <= `mepc`.
  - FSM -> `REDIRECT`.
- **REDIRECT:**
  - `redirect_o` = 1 and `stall_o` = 1.
  - `excPresent_i` and `mret_i` are ignored.
  - When `fetchReady_i` = 1, FSM -> `IDLE` on the next edge.
- **Priority:** a taken trap beats `mret_i` in the same cycle.
- **CSR write in the same cycle as a commit:**
  - Trap/mret updates win for `mepc`, `mcause`, `mtval` and `mstatus`.
  - Writes to `mie` and `mtvec` proceed normally.
- **Write masks:**
  - `mstatus`: only bits 3 and 7 are writable; all other bits read 0.
  - `mie`: only bit 7 is writable.
  - `mip`: read-only.
  - `mepc`: bits [1:0] are forced to 0.
- **Write timing:** CSR writes are accepted in either state.

## Timing
- **Reset values:**
  - `redirect_o` = 0, `redirectPc_o` = 0, `trapTaken_o` = 0.
  - `mstatus`, `mie`, `mepc`, `mcause`, `mtval` = 0.
  - `mtvec` = `MTVEC_RESET`.
  - FSM = `IDLE`.
- **`stall_o`** = (state == `REDIRECT`) OR (`IDLE` and (trap taken or `mret_i`)). It is combinational, so the faulting instruction is frozen in cycle N.
- **Latency:** request in cycle N -> `redirect_o` high from cycle N+1. `trapTaken_o` pulses in cycle N+1 for traps only.
- **Hold:** `redirect_o` and `redirectPc_o` stay stable until the cycle in which `fetchReady_i` is sampled high. They drop in the following cycle.
  - Minimum redirect duration is 1 cycle, when `fetchReady_i` is already high in N+1.
- **Back-to-back:** a new request in the cycle right after return to `IDLE` is accepted normally.
- **Reset mid-REDIRECT:** everything is cleared immediately (asynchronous); no redirect is issued afterwards.
- **Width rule:** vector target arithmetic is 32-bit modulo; wrap-around is allowed and not flagged.

## Configuration
- **`TRAP_VECTORED_EN` defined:**
  - `mtvec[1:0]` = 2'b01 selects vectored mode.
  - In vectored mode, interrupts target {`mtvec[31:2]`,2'b00} + 4·`excCause_i[30:0]`.
  - Exceptions always target the base.
  - `mtvec[1:0]` is writable with values 0 and 1; writes of 2 or 3 store 0.
- **`TRAP_VECTORED_EN` undefined:**
  - `mtvec[1:0]` is hardwired to 0 and reads 0.
  - All traps target {`mtvec[31:2]`,2'b00}.

## Structure
- **`riscV_unrn_pkg`:**
  - CSR address constants: `CSR_MSTATUS` 12'h300, `CSR_MIE` 12'h304, `CSR_MTVEC` 12'h305, `CSR_MEPC` 12'h341, `CSR_MCAUSE` 12'h342, `CSR_MTVAL` 12'h343, `CSR_MIP` 12'h344.
  - Bit-position constants `MSTATUS_MIE`=3, `MSTATUS_MPIE`=7, `MIX_MTI`=7.
  - FSM enum `trap_state_t`.
- **Sub-module `trap_csr_file`:** register storage, write masks and read mux. `trap_ctrl` keeps the FSM, the priority logic and the target computation.

## Test plan
- **Illegal instruction trap:** `mtvec`=0x100; `excPresent_i`=1, cause=2, `pc_i`=0x208, info=0x208, `fetchReady_i`=1.
  - -> N+1: `redirect_o`=1, `redirectPc_o`=0x100, `trapTaken_o`=1.
  - -> `mepc`=0x208, `mcause`=2, `mtval`=0x208, `MIE`=0.
- **Masked timer interrupt:** `MIE`=0, cause=0x8000_0007.
  - -> no redirect, `stall_o`=0, all CSRs unchanged.
- **Return:** after the first scenario, `mret_i`=1 with `MPIE`=1.
  - -> `redirectPc_o`=0x208, `MIE`=1, `MPIE`=1.
- **Handshake hold:** hold `fetchReady_i`=0 for 3 cycles.
  - -> `redirect_o`/`redirectPc_o` stable for 4 cycles, `stall_o`=1 throughout.
  - -> `excPresent_i` pulses during this time are ignored.
- **Vectored interrupt (`TRAP_VECTORED_EN`):** `mtvec`=0x101, `MIE`=`MTIE`=1, cause=0x8000_0007.
  - -> target 0x11C.
  - -> Without the macro: target 0x100 and `mtvec` reads 0x100.
- **Reset and priority:**
  - Assert `rst_i` mid-REDIRECT -> `redirect_o`=0 immediately.
  - Simultaneous trap and `mret_i` -> trap taken, `mepc` written.
